// File: rtl/bridge_wb_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: state encoding,
// timeout read-data pattern and grant bit indices.
package bridge_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [31:0] TIMEOUT_RDT = 32'hDEAD_BEEF;

    localparam int unsigned GRANT_M0 = 0;
    localparam int unsigned GRANT_M1 = 1;

endpackage

// File: rtl/bridge_arb_timeout.sv
// Acknowledge-timeout counter: clears on request, counts while enabled and
// flags expiry when the count reaches TIMEOUT_CYC-1.
module bridge_arb_timeout #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC - 1);

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 16'd1;
        end
    end

    assign expire = (count == LIMIT);

endmodule

// File: rtl/bridge_wb_arbiter.sv
// Two-master to one-target Wishbone arbiter with alternating tie-break.
// Optional acknowledge timeout enabled by defining BRIDGE_ARB_TIMEOUT_EN.
module bridge_wb_arbiter
    import bridge_wb_arbiter_pkg::*;
#(
    parameter int unsigned AW          = 12,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-3:0] i_m0_adr,
    input  logic [31:0]   i_m0_dat,
    input  logic [3:0]    i_m0_sel,
    input  logic          i_m0_we,
    input  logic          i_m0_stb,
    output logic [31:0]   o_m0_rdt,
    output logic          o_m0_ack,
    input  logic [AW-3:0] i_m1_adr,
    input  logic [31:0]   i_m1_dat,
    input  logic [3:0]    i_m1_sel,
    input  logic          i_m1_we,
    input  logic          i_m1_stb,
    output logic [31:0]   o_m1_rdt,
    output logic          o_m1_ack,
    output logic [AW-3:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_stb,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack,
    output logic [1:0]    o_grant,
    output logic          o_err
);

    state_t state, state_next;
    logic   last_grant, last_grant_next;
    logic   owner_stb;
    logic   expire;
    logic   timeout;

`ifdef BRIDGE_ARB_TIMEOUT_EN
    bridge_arb_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk   (i_clk),
        .rst   (i_rst),
        .clear (state == IDLE),
        .enable((state != IDLE) && !i_wb_ack),
        .expire(expire)
    );
`else
    // Range flag keeps TIMEOUT_CYC referenced when the timeout is compiled out.
    localparam bit TIMEOUT_RANGE_OK = (TIMEOUT_CYC >= 1) && (TIMEOUT_CYC <= 65535);
    assign expire = 1'b0 & TIMEOUT_RANGE_OK;
`endif

    assign owner_stb = (state == OWN0) ? i_m0_stb :
                       (state == OWN1) ? i_m1_stb : 1'b0;
    assign timeout   = owner_stb && !i_wb_ack && expire;
    assign o_err     = timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            last_grant <= 1'(GRANT_M1);
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        o_wb_adr        = '0;
        o_wb_dat        = '0;
        o_wb_sel        = '0;
        o_wb_we         = 1'b0;
        o_wb_stb        = 1'b0;
        o_m0_ack        = 1'b0;
        o_m0_rdt        = '0;
        o_m1_ack        = 1'b0;
        o_m1_rdt        = '0;

        case (state)
            IDLE: begin
                // On a tie, serve whichever master was not granted last.
                if (i_m0_stb && i_m1_stb) begin
                    state_next = (last_grant == 1'(GRANT_M1)) ? OWN0 : OWN1;
                end else if (i_m0_stb) begin
                    state_next = OWN0;
                end else if (i_m1_stb) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                o_wb_adr = i_m0_adr;
                o_wb_dat = i_m0_dat;
                o_wb_sel = i_m0_sel;
                o_wb_we  = i_m0_we;
                o_wb_stb = i_m0_stb && !timeout;
                o_m0_ack = i_wb_ack || timeout;
                o_m0_rdt = timeout ? TIMEOUT_RDT : i_wb_rdt;
                if (i_wb_ack || timeout) begin
                    state_next      = IDLE;
                    last_grant_next = 1'(GRANT_M0);
                end else if (!i_m0_stb) begin
                    state_next = IDLE;
                end
            end
            OWN1: begin
                o_wb_adr = i_m1_adr;
                o_wb_dat = i_m1_dat;
                o_wb_sel = i_m1_sel;
                o_wb_we  = i_m1_we;
                o_wb_stb = i_m1_stb && !timeout;
                o_m1_ack = i_wb_ack || timeout;
                o_m1_rdt = timeout ? TIMEOUT_RDT : i_wb_rdt;
                if (i_wb_ack || timeout) begin
                    state_next      = IDLE;
                    last_grant_next = 1'(GRANT_M1);
                end else if (!i_m1_stb) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_grant           = '0;
        o_grant[GRANT_M0] = (state == OWN0);
        o_grant[GRANT_M1] = (state == OWN1);
    end

endmodule

// File: tb/tb_bridge_wb_arbiter.sv
// Randomized and directed bench for bridge_wb_arbiter against a transaction-level
// ownership model; honours BRIDGE_ARB_TIMEOUT_EN (TIMEOUT_CYC = 4 when defined).
module tb_bridge_wb_arbiter;

    localparam int unsigned AW = 12;
`ifdef BRIDGE_ARB_TIMEOUT_EN
    localparam int unsigned TCYC   = 4;
    localparam bit          TMO_EN = 1'b1;
`else
    localparam int unsigned TCYC   = 255;
    localparam bit          TMO_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [AW-3:0] m0_adr, m1_adr, wb_adr;
    logic [31:0]   m0_dat, m1_dat, wb_dat;
    logic [3:0]    m0_sel, m1_sel, wb_sel;
    logic          m0_we, m1_we, wb_we;
    logic          m0_stb, m1_stb, wb_stb;
    logic [31:0]   m0_rdt, m1_rdt, wb_rdt;
    logic          m0_ack, m1_ack, wb_ack;
    logic [1:0]    grant;
    logic          err;

    bridge_wb_arbiter #(
        .AW         (AW),
        .TIMEOUT_CYC(TCYC)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_m0_adr(m0_adr),
        .i_m0_dat(m0_dat),
        .i_m0_sel(m0_sel),
        .i_m0_we (m0_we),
        .i_m0_stb(m0_stb),
        .o_m0_rdt(m0_rdt),
        .o_m0_ack(m0_ack),
        .i_m1_adr(m1_adr),
        .i_m1_dat(m1_dat),
        .i_m1_sel(m1_sel),
        .i_m1_we (m1_we),
        .i_m1_stb(m1_stb),
        .o_m1_rdt(m1_rdt),
        .o_m1_ack(m1_ack),
        .o_wb_adr(wb_adr),
        .o_wb_dat(wb_dat),
        .o_wb_sel(wb_sel),
        .o_wb_we (wb_we),
        .o_wb_stb(wb_stb),
        .i_wb_rdt(wb_rdt),
        .i_wb_ack(wb_ack),
        .o_grant (grant),
        .o_err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int err_seen = 0;
    bit chk_en   = 1'b0;

    // Reference model: which master owns the bus (0 none, 1 m0, 2 m1),
    // which master was served last, and how many cycles the owner has held it.
    int owner  = 0;
    int last_m = 1;
    int age    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic rand_fields();
        m0_adr = AW'($urandom) >> 2;
        m1_adr = AW'($urandom) >> 2;
        m0_dat = $urandom;
        m1_dat = $urandom;
        m0_sel = 4'($urandom);
        m1_sel = 4'($urandom);
        m0_we  = 1'($urandom);
        m1_we  = 1'($urandom);
        wb_rdt = $urandom;
    endtask

    task automatic tick();
        logic [46:0] req0, req1, e_req;
        logic [31:0] e_rdt0, e_rdt1, rdtv;
        logic [1:0]  e_gnt;
        logic        e_stb, e_ack0, e_ack1, e_err, stbn, to, ackv;
        @(negedge clk);
        if (err) err_seen++;
        if (chk_en) begin
            req0   = {m0_adr, m0_dat, m0_sel, m0_we};
            req1   = {m1_adr, m1_dat, m1_sel, m1_we};
            e_req  = '0;
            e_gnt  = 2'b00;
            e_stb  = 1'b0;
            e_ack0 = 1'b0;
            e_ack1 = 1'b0;
            e_rdt0 = '0;
            e_rdt1 = '0;
            e_err  = 1'b0;
            if (owner != 0) begin
                stbn  = (owner == 1) ? m0_stb : m1_stb;
                to    = TMO_EN && stbn && !wb_ack && (age == int'(TCYC));
                ackv  = wb_ack || to;
                rdtv  = to ? 32'hDEAD_BEEF : wb_rdt;
                e_gnt = (owner == 1) ? 2'b01 : 2'b10;
                e_req = (owner == 1) ? req0 : req1;
                e_stb = stbn && !to;
                e_err = to;
                if (owner == 1) begin
                    e_ack0 = ackv;
                    e_rdt0 = rdtv;
                end else begin
                    e_ack1 = ackv;
                    e_rdt1 = rdtv;
                end
            end
            check("grant", 64'(grant), 64'(e_gnt));
            check("wb_stb", 64'(wb_stb), 64'(e_stb));
            check("wb_req", 64'({wb_adr, wb_dat, wb_sel, wb_we}), 64'(e_req));
            check("m0_ack", 64'(m0_ack), 64'(e_ack0));
            check("m1_ack", 64'(m1_ack), 64'(e_ack1));
            check("m0_rdt", 64'(m0_rdt), 64'(e_rdt0));
            check("m1_rdt", 64'(m1_rdt), 64'(e_rdt1));
            check("err", 64'(err), 64'(e_err));
        end
        @(posedge clk);
        if (rst) begin
            owner  = 0;
            last_m = 1;
            age    = 0;
        end else if (owner == 0) begin
            if (m0_stb && m1_stb) owner = (last_m == 1) ? 1 : 2;
            else if (m0_stb)      owner = 1;
            else if (m1_stb)      owner = 2;
            age = 1;
        end else begin
            stbn = (owner == 1) ? m0_stb : m1_stb;
            to   = TMO_EN && stbn && !wb_ack && (age == int'(TCYC));
            if (wb_ack || to) begin
                last_m = owner - 1;
                owner  = 0;
            end else if (!stbn) begin
                owner = 0;
            end else begin
                age++;
            end
        end
        chk_en = 1'b1;
        #1;
    endtask

    task automatic drive(input logic r, input logic s0, input logic s1, input logic a);
        rst    = r;
        m0_stb = s0;
        m1_stb = s1;
        wb_ack = a;
    endtask

    initial begin
        rand_fields();
        drive(1, 0, 0, 0);
        tick();
        tick();
        check("rst_grant", 64'(grant), 64'(2'b00));

        // m0 write, target acks in the second owned cycle.
        m0_adr = 10'h010;
        m0_dat = 32'hA5A5_A5A5;
        m0_sel = 4'hF;
        m0_we  = 1'b1;
        drive(0, 1, 0, 0);
        tick();
        check("m0_grant", 64'(grant), 64'(2'b01));
        tick();
        drive(0, 1, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        tick();
        check("m0_done", 64'(grant), 64'(2'b00));

        // Tie alternation over four rounds, each served with an immediate ack.
        drive(1, 1, 1, 0);
        tick();
        for (int r = 0; r < 4; r++) begin
            drive(0, 1, 1, 0);
            tick();
            check("alt_grant", 64'(grant), 64'((r % 2 == 0) ? 2'b01 : 2'b10));
            drive(0, 1, 1, 1);
            tick();
        end

        // m1 read with known data.
        m1_adr = 10'h03F;
        m1_we  = 1'b0;
        wb_rdt = 32'h1234_5678;
        drive(0, 0, 1, 0);
        tick();
        drive(0, 0, 1, 1);
        tick();
        drive(0, 0, 0, 0);
        tick();

        // m0 abort after three owned cycles, m1 waiting.
        drive(0, 1, 1, 0);
        tick();
        tick();
        tick();
        drive(0, 0, 1, 0);
        tick();
        tick();
        check("abort_m1", 64'(grant), 64'(2'b10));

        // Reset mid-OWN1, then a tie must go to m0.
        drive(1, 1, 1, 0);
        tick();
        check("rst_own1", 64'(grant), 64'(2'b00));
        drive(0, 1, 1, 0);
        tick();
        check("tie_m0_first", 64'(grant), 64'(2'b01));

        // Target never acknowledges for 100 cycles.
        drive(1, 0, 0, 0);
        tick();
        err_seen = 0;
        drive(0, 1, 0, 0);
        for (int i = 0; i < 100; i++) tick();
`ifdef BRIDGE_ARB_TIMEOUT_EN
        check("tmo_pulses", 64'(err_seen), 64'(20));
`else
        check("hold_grant", 64'(grant), 64'(2'b01));
        check("no_err", 64'(err_seen), 64'(0));
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_fields();
            drive(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
